mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between an instruction-fetch port and a data port (data first).
// Define ARB_FAIRNESS_EN to force a fetch grant after STARVE_MAX back-to-back data grants.
//
// state   | meaning
// IDLE    | no transaction; grants a waiting port unless a valid is pulsing this cycle
// IF_BUSY | fetch presented on mem_*, waiting for mem_ready
// D_BUSY  | load/store presented on mem_*, waiting for mem_ready
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_valid,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_valid,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    D_BUSY  = 2'd2
  } state_t;

  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("mem_port_arbiter: STARVE_MAX must be in 1..15");
  end

  state_t            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [BE_W-1:0]   mem_be_q, mem_be_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_valid_q, if_valid_d;
  logic              d_valid_q, d_valid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic grant_ok, grant_data, grant_fetch, force_fetch;

  // A valid pulse means the core still holds the old request this cycle; never re-grant on it.
  assign grant_ok    = (state_q == IDLE) && !if_valid_q && !d_valid_q;
  assign grant_data  = grant_ok && d_req && !force_fetch;
  assign grant_fetch = grant_ok && if_req && !grant_data;

`ifdef ARB_FAIRNESS_EN
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_q, starve_d;

  assign force_fetch = if_req && (starve_q >= STARVE_LIM);

  always_comb begin
    starve_d = starve_q;
    if (grant_fetch) begin
      starve_d = '0;
    end else if (grant_data && if_req && (starve_q != 4'hF)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign force_fetch = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (grant_data) begin
          state_d     = D_BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_be_d    = d_be;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
        end else if (grant_fetch) begin
          state_d    = IF_BUSY;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_be_d   = '1;
          mem_addr_d = if_addr;
        end
      end
      IF_BUSY: begin
        if (mem_ready) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          if_valid_d = 1'b1;
          if_rdata_d = mem_rdata;
        end
      end
      D_BUSY: begin
        if (mem_ready) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          d_valid_d = 1'b1;
          // Stores leave the last load result visible to the core.
          if (!mem_we_q) begin
            d_rdata_d = mem_rdata;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_valid  = if_valid_q;
  assign d_valid   = d_valid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

  assign stall = (if_req && !if_valid_q) || (d_req && !d_valid_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int SMAX = 4;
`ifdef ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ready = 1'b0;
  logic [AW-1:0] if_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0, mem_rdata = '0;
  logic [BW-1:0] d_be = '0;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [BW-1:0] mem_be;
  logic          if_valid, d_valid, mem_req, mem_we, stall;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .stall(stall)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // memarr is the memory the DUT sees; refmem is the model's view of the same memory.
  logic [31:0] memarr [256];
  logic [31:0] refmem [256];

  // Model: at most one transaction in flight, described by which port owns it and its fields.
  int          m_port = 0;      // 0 none, 1 fetch, 2 data
  logic [31:0] m_addr = '0, m_wdata = '0;
  logic        m_we = 1'b0;
  logic [3:0]  m_be = '0;
  int          m_starve = 0;
  logic        e_ifv = 1'b0, e_dv = 1'b0;
  logic [31:0] e_ifr = '0, e_dr = '0;

  logic        s_rst, s_if_req, s_d_req, s_d_we, s_mem_ready, s_mreq, s_mwe;
  logic [31:0] s_if_addr, s_d_addr, s_d_wdata, s_maddr, s_mwdata;
  logic [3:0]  s_d_be, s_mbe;

  initial begin
    for (int i = 0; i < 256; i++) begin
      logic [31:0] v;
      v = $urandom;
      memarr[i] = v;
      refmem[i] = v;
    end
    memarr[4] = 32'h00500093;
    refmem[4] = 32'h00500093;
    forever begin
      @(negedge clk);
      #1;
      chk("stall", 32'(stall), 32'((if_req && !e_ifv) || (d_req && !e_dv)));
      s_rst = rst; s_if_req = if_req; s_if_addr = if_addr;
      s_d_req = d_req; s_d_we = d_we; s_d_be = d_be; s_d_addr = d_addr; s_d_wdata = d_wdata;
      s_mem_ready = mem_ready; s_mreq = mem_req; s_mwe = mem_we; s_maddr = mem_addr;
      s_mbe = mem_be; s_mwdata = mem_wdata;
      @(posedge clk);
      if (!s_rst && s_mreq && s_mem_ready && s_mwe)
        memarr[s_maddr[9:2]] = merge(memarr[s_maddr[9:2]], s_mwdata, s_mbe);
      if (s_rst) begin
        m_port = 0; m_starve = 0; e_ifv = 1'b0; e_dv = 1'b0; e_ifr = '0; e_dr = '0;
      end else begin
        logic nifv, ndv;
        nifv = 1'b0;
        ndv  = 1'b0;
        if (m_port == 1) begin
          if (s_mem_ready) begin
            nifv = 1'b1; e_ifr = refmem[m_addr[9:2]]; m_port = 0;
          end
        end else if (m_port == 2) begin
          if (s_mem_ready) begin
            ndv = 1'b1;
            if (m_we) refmem[m_addr[9:2]] = merge(refmem[m_addr[9:2]], m_wdata, m_be);
            else e_dr = refmem[m_addr[9:2]];
            m_port = 0;
          end
        end else if (!e_ifv && !e_dv) begin
          bit forced;
          forced = FAIR && (m_starve >= SMAX) && s_if_req;
          if (s_d_req && !forced) begin
            m_port = 2; m_addr = s_d_addr; m_we = s_d_we; m_be = s_d_be; m_wdata = s_d_wdata;
            if (s_if_req && m_starve < 15) m_starve++;
          end else if (s_if_req) begin
            m_port = 1; m_addr = s_if_addr; m_we = 1'b0; m_starve = 0;
          end
        end
        e_ifv = nifv;
        e_dv  = ndv;
      end
      #1;
      chk("mem_req", 32'(mem_req), 32'(m_port != 0));
      if (m_port != 0) begin
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_we", 32'(mem_we), 32'(m_we));
        if (m_port == 2) begin
          chk("mem_be", 32'(mem_be), 32'(m_be));
          if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
        end
      end
      chk("if_valid", 32'(if_valid), 32'(e_ifv));
      chk("d_valid", 32'(d_valid), 32'(e_dv));
      chk("if_rdata", if_rdata, e_ifr);
      chk("d_rdata", d_rdata, e_dr);
    end
  end

  task automatic drive_mem(input int unsigned pct);
    mem_ready = !rst && ($urandom_range(0, 99) < pct);
    mem_rdata = mem_req ? memarr[mem_addr[9:2]] : $urandom;
  endtask

  function automatic logic [31:0] rand_addr();
    return {22'h0, 4'h0, 4'($urandom_range(0, 15)), 2'b00};
  endfunction

  initial begin
    int nd, nf, nd_before;
    logic prev_req;

    repeat (3) @(negedge clk);
    chk("rst mem_req", 32'(mem_req), 32'h0);
    chk("rst mem_we", 32'(mem_we), 32'h0);
    chk("rst if_valid", 32'(if_valid), 32'h0);
    chk("rst d_valid", 32'(d_valid), 32'h0);
    chk("rst mem_be", 32'(mem_be), 32'h0);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst mem_wdata", mem_wdata, 32'h0);
    chk("rst if_rdata", if_rdata, 32'h0);
    chk("rst d_rdata", d_rdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Fetch only, zero wait states.
    if_req = 1'b1; if_addr = 32'h10;
    @(negedge clk);
    chk("fo mem_req", 32'(mem_req), 32'h1);
    chk("fo mem_addr", mem_addr, 32'h10);
    chk("fo early if_valid", 32'(if_valid), 32'h0);
    mem_ready = 1'b1; mem_rdata = 32'h00500093;
    @(negedge clk);
    chk("fo if_valid", 32'(if_valid), 32'h1);
    chk("fo if_rdata", if_rdata, 32'h00500093);
    chk("fo mem_req drop", 32'(mem_req), 32'h0);
    if_req = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    chk("fo pulse width", 32'(if_valid), 32'h0);
    mem_ready = 1'b1; mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    chk("idle ready ignored", 32'({mem_req, if_valid, d_valid}), 32'h0);
    mem_ready = 1'b0;
    @(negedge clk);

    // Simultaneous store and fetch: data first.
    if_req = 1'b1; if_addr = 32'h10;
    d_req = 1'b1; d_addr = 32'h100; d_we = 1'b1; d_wdata = 32'hDEADBEEF; d_be = 4'hF;
    @(negedge clk);
    chk("sim stall", 32'(stall), 32'h1);
    chk("sim mem_we", 32'(mem_we), 32'h1);
    chk("sim mem_addr", mem_addr, 32'h100);
    chk("sim mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("sim mem_be", 32'(mem_be), 32'hF);
    mem_ready = 1'b1;
    @(negedge clk);
    chk("sim d_valid", 32'(d_valid), 32'h1);
    chk("sim store keeps d_rdata", d_rdata, 32'h0);
    chk("sim stall fetch wait", 32'(stall), 32'h1);
    d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    chk("sim no grant on valid", 32'(mem_req), 32'h0);
    chk("sim stall held", 32'(stall), 32'h1);
    @(negedge clk);
    chk("sim fetch grant", 32'(mem_req), 32'h1);
    chk("sim fetch we", 32'(mem_we), 32'h0);
    chk("sim fetch addr", mem_addr, 32'h10);
    mem_ready = 1'b1; mem_rdata = memarr[4];
    @(negedge clk);
    chk("sim if_valid", 32'(if_valid), 32'h1);
    chk("sim if_rdata", if_rdata, 32'h00500093);
    chk("sim stall released", 32'(stall), 32'h0);
    if_req = 1'b0; mem_ready = 1'b0;
    @(negedge clk);

    // Load with three wait states; reads back the earlier store.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_be = 4'hF;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("ws mem_req", 32'(mem_req), 32'h1);
      chk("ws mem_addr", mem_addr, 32'h100);
      chk("ws mem_we", 32'(mem_we), 32'h0);
      chk("ws d_valid early", 32'(d_valid), 32'h0);
      if (i == 4) begin
        mem_ready = 1'b1; mem_rdata = memarr[64];
      end
    end
    @(negedge clk);
    chk("ws d_valid at 5", 32'(d_valid), 32'h1);
    chk("ws d_rdata", d_rdata, 32'hDEADBEEF);
    d_req = 1'b0; mem_ready = 1'b0;
    @(negedge clk);

    // Reset while D_BUSY, then a stray mem_ready.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    @(negedge clk);
    chk("rm busy", 32'(mem_req), 32'h1);
    rst = 1'b1; d_req = 1'b0;
    @(negedge clk);
    chk("rm mem_req", 32'(mem_req), 32'h0);
    rst = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h12345678;
    @(negedge clk);
    chk("rm no d_valid", 32'(d_valid), 32'h0);
    chk("rm d_rdata", d_rdata, 32'h0);
    chk("rm mem_addr", mem_addr, 32'h0);
    mem_ready = 1'b0;
    @(negedge clk);
    chk("rm no late d_valid", 32'(d_valid), 32'h0);

    // Both ports held high: arbitration order.
    if_req = 1'b1; if_addr = 32'h20;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; d_be = 4'hF;
    nd = 0; nf = 0; nd_before = 0; prev_req = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (mem_req && !prev_req) begin
        if (mem_addr == 32'h20) nf++;
        else begin
          nd++;
          if (nf == 0) nd_before++;
        end
      end
      prev_req = mem_req;
      drive_mem(100);
    end
`ifdef ARB_FAIRNESS_EN
    chk("fair data before fetch", 32'(nd_before), 32'(SMAX));
    chk("fair fetch served", 32'(nf > 0), 32'h1);
`else
    chk("strict no fetch", 32'(nf), 32'h0);
    chk("strict data served", 32'(nd > 10), 32'h1);
`endif
    if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
    repeat (4) @(negedge clk);

    // Random traffic.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      int unsigned pct;
      @(negedge clk);
      pct = (cyc / 500) % 2 == 0 ? 60 : 25;
      rst = ($urandom_range(0, 249) == 0);
      if (if_req) begin
        if (if_valid) begin
          if ($urandom_range(0, 1) == 0) if_req = 1'b0;
          else if_addr = rand_addr();
        end else if ($urandom_range(0, 59) == 0) if_req = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        if_req = 1'b1; if_addr = rand_addr();
      end
      if (d_req) begin
        if (d_valid) begin
          if ($urandom_range(0, 1) == 0) d_req = 1'b0;
          else begin
            d_addr = rand_addr(); d_we = 1'($urandom_range(0, 1));
            d_be = 4'($urandom_range(1, 15)); d_wdata = $urandom;
          end
        end else if ($urandom_range(0, 59) == 0) d_req = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        d_req = 1'b1; d_addr = rand_addr(); d_we = 1'($urandom_range(0, 1));
        d_be = 4'($urandom_range(1, 15)); d_wdata = $urandom;
      end
      drive_mem(pct);
    end
    @(negedge clk);
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
